ahb_lite_sram_slave: RTL and testbench

AHB-Lite responder that terminates a processor memory/MMIO master port and serves a single-port synchronous SRAM of 32-bit words. It implements the full address-phase/data-phase pipeline with byte, halfword and word writes, read-during-write forwarding and programmable wait states. It is the slave end of the processor AHB master interfaces and sits behind the memory or IO fabric.

---
 rtl/ahb_lite_sram_slave.sv | 109 ++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave: AHB-Lite slave over a single-port 32-bit SRAM with byte lanes, write forwarding and wait states.
// Define AHB_SRAM_ERR_RESP_EN to answer out-of-range, oversized or misaligned accesses with a two-cycle ERROR.
module ahb_lite_sram_slave #(
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int WAIT_STATES     = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP
);
    localparam int IW = $clog2(MEM_DEPTH_WORDS);
    localparam int AW = IW + 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            dp_wr_q, dp_wr_d;
    logic [IW-1:0]   dp_idx_q, dp_idx_d;
    logic [3:0]      dp_mask_q, dp_mask_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     mem [MEM_DEPTH_WORDS];
    logic            acc, bad, wr_fire;
    logic [IW-1:0]   acc_idx;
    logic [3:0]      acc_mask;
    logic [31:0]     rd_word;
    logic            unused;

    assign unused   = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:AW]};
    assign acc      = HSEL & HREADYIN & HTRANS[1] & HREADYOUT;
    assign acc_idx  = HADDR[AW-1:2];
    assign acc_mask = (HSIZE == 3'd0) ? 4'b0001 << HADDR[1:0] :
                      (HSIZE == 3'd1) ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef AHB_SRAM_ERR_RESP_EN
    assign bad = (|HADDR[31:AW]) | (HSIZE > 3'd2) | ((HSIZE == 3'd1) & HADDR[0]) |
                 ((HSIZE == 3'd2) & (|HADDR[1:0]));
`else
    assign bad = 1'b0;
`endif
    assign wr_fire = dp_wr_q & HREADYOUT;

    // A read accepted on the edge that retires a write to the same word sees the new lanes
    always_comb begin
        rd_word = mem[acc_idx];
        for (int i = 0; i < 4; i++)
            if (wr_fire && dp_idx_q == acc_idx && dp_mask_q[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
    end

    always_comb begin
        dp_wr_d   = HREADYOUT ? (acc & HWRITE & ~bad) : dp_wr_q;
        dp_idx_d  = acc ? acc_idx : dp_idx_q;
        dp_mask_d = acc ? acc_mask : dp_mask_q;
        rdata_d   = (acc & ~HWRITE & ~bad) ? rd_word : rdata_q;
        cnt_d     = acc ? 2'(WAIT_STATES) : (state_q == S_WAIT) ? cnt_q - 2'd1 : cnt_q;
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dp_wr_q   <= 1'b0;
            dp_idx_q  <= '0;
            dp_mask_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_wr_q   <= dp_wr_d;
            dp_idx_q  <= dp_idx_d;
            dp_mask_q <= dp_mask_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERR2: state_d = !acc ? S_IDLE : bad ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
            S_WAIT:         state_d = (cnt_q == 2'd1) ? S_IDLE : S_WAIT;
            S_ERR1:         state_d = S_ERR2;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = (state_q == S_IDLE) || (state_q == S_ERR2);
        HRESP     = {1'b0, (state_q == S_ERR1) || (state_q == S_ERR2)};
        HRDATA    = rdata_q;
    end

    // SRAM array is not reset; a discarded write simply never fires
    always_ff @(posedge HCLK) begin
        if (wr_fire)
            for (int i = 0; i < 4; i++)
                if (dp_mask_q[i]) mem[dp_idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// tb_ahb_lite_sram_slave: directed AHB-Lite traffic against a zero-wait and a two-wait-state slave.
// Read expectations are queued at address phase and popped when the data phase completes.
module tb_ahb_lite_sram_slave;
`ifdef AHB_SRAM_ERR_RESP_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, hsel, tgt, hwrite;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        ro0, ro1, hready;
    logic [31:0] rd0, rd1, hrdata;
    logic [1:0]  rs0, rs1, hresp;
    logic [31:0] exp_q [$];
    logic        rd_dp;
    int          n_chk, n_fail, lowcnt, cyc, l0, c0;

    always #5 clk = ~clk;

    assign hready = tgt ? ro1 : ro0;
    assign hrdata = tgt ? rd1 : rd0;
    assign hresp  = tgt ? rs1 : rs0;

    ahb_lite_sram_slave #(.MEM_DEPTH_WORDS(4096), .WAIT_STATES(0)) u_ws0 (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel & ~tgt), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b0), .HPROT(4'b0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADYIN(hready), .HREADYOUT(ro0), .HRDATA(rd0), .HRESP(rs0)
    );

    ahb_lite_sram_slave #(.MEM_DEPTH_WORDS(4096), .WAIT_STATES(2)) u_ws2 (
        .HCLK(clk), .HRESETN(rst_n), .HSEL(hsel & tgt), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b0), .HPROT(4'b0), .HMASTLOCK(1'b0),
        .HWDATA(hwdata), .HREADYIN(hready), .HREADYOUT(ro1), .HRDATA(rd1), .HRESP(rs1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hready) break;
        end
        chk("ready_timeout", 32'(hready), 32'd1);
    endtask

    task automatic xfer(input logic [1:0] tr, input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] d, input logic [31:0] e);
        htrans = tr;
        hwrite = w;
        haddr  = a;
        hsize  = sz;
        if (tr[1] && !w) exp_q.push_back(e);
        wait_ready();
        @(posedge clk);
        #1;
        if (tr[1] && w) hwdata = d;
        else if (tr == 2'd1) hwdata = 32'hFFFF_FFFF;
    endtask

    task automatic idle(input int n);
        htrans = 2'd0;
        repeat (n) begin
            wait_ready();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; lowcnt = 0; cyc = 0; rd_dp = 1'b0;
        rst_n = 1'b0; hsel = 1'b0; tgt = 1'b0; hwrite = 1'b0;
        haddr = '0; hwdata = '0; htrans = 2'd0; hsize = 3'd2;
        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (!rst_n) rd_dp = 1'b0;
                else if (!hready) lowcnt++;
                else begin
                    if (rd_dp) begin
                        if (exp_q.size() == 0) chk("rd_unexpected", 32'd0, 32'd1);
                        else chk("rdata", hrdata, exp_q.pop_front());
                    end
                    rd_dp = hsel && htrans[1] && !hwrite;
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_ready0", 32'(ro0), 32'd1);
        chk("rst_resp0", 32'(rs0), 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_ready2", 32'(ro1), 32'd1);
        chk("rst_resp2", 32'(rs1), 32'd0);
        chk("rst_rdata2", rd1, 32'd0);
        @(posedge clk);
        #1 hsel = 1'b1;

        // Reset in the middle of a write data phase
        xfer(2'd2, 1'b1, 32'h10, 3'd2, 32'h1111_1111, 0);
        xfer(2'd2, 1'b0, 32'h10, 3'd2, 0, 32'h1111_1111);
        idle(1);
        xfer(2'd2, 1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 0);
        htrans = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ro0), 32'd1);
        chk("midrst_resp", 32'(rs0), 32'd0);
        chk("midrst_rdata", rd0, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(2'd2, 1'b0, 32'h10, 3'd2, 0, 32'h1111_1111);
        idle(1);

        // Back-to-back write/read with forwarding, never stalling
        l0 = lowcnt;
        xfer(2'd2, 1'b1, 32'h20, 3'd2, 32'h1234_5678, 0);
        xfer(2'd2, 1'b0, 32'h20, 3'd2, 0, 32'h1234_5678);
        idle(1);
        chk("ws0_no_stall", 32'(lowcnt - l0), 32'd0);

        // Byte and halfword lanes with junk on the unused lanes
        xfer(2'd2, 1'b1, 32'h40, 3'd2, 32'h0000_0000, 0);
        xfer(2'd2, 1'b1, 32'h41, 3'd0, 32'h5555_AA55, 0);
        xfer(2'd2, 1'b1, 32'h42, 3'd1, 32'hBEEF_7777, 0);
        xfer(2'd2, 1'b0, 32'h40, 3'd2, 0, 32'hBEEF_AA00);
        xfer(2'd2, 1'b0, 32'h41, 3'd0, 0, 32'hBEEF_AA00);
        idle(1);

        // INCR4 burst with a BUSY beat
        xfer(2'd2, 1'b1, 32'h100, 3'd2, 32'h1, 0);
        xfer(2'd3, 1'b1, 32'h104, 3'd2, 32'h2, 0);
        xfer(2'd1, 1'b1, 32'h108, 3'd2, 0, 0);
        chk("busy_resp", 32'(hresp), 32'd0);
        chk("busy_ready", 32'(hready), 32'd1);
        xfer(2'd3, 1'b1, 32'h108, 3'd2, 32'h3, 0);
        xfer(2'd3, 1'b1, 32'h10C, 3'd2, 32'h4, 0);
        xfer(2'd2, 1'b0, 32'h100, 3'd2, 0, 32'h1);
        xfer(2'd2, 1'b0, 32'h104, 3'd2, 0, 32'h2);
        xfer(2'd2, 1'b0, 32'h108, 3'd2, 0, 32'h3);
        xfer(2'd2, 1'b0, 32'h10C, 3'd2, 0, 32'h4);
        idle(1);

        // Misaligned word write: ERROR with the option, aligned write without it
        xfer(2'd2, 1'b1, 32'h102, 3'd2, 32'hCAFE_F00D, 0);
        htrans = 2'd0;
        chk("mis_c1_ready", 32'(hready), ERR ? 32'd0 : 32'd1);
        chk("mis_c1_resp", 32'(hresp), ERR ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        chk("mis_c2_ready", 32'(hready), 32'd1);
        chk("mis_c2_resp", 32'(hresp), ERR ? 32'd1 : 32'd0);
        idle(1);
        xfer(2'd2, 1'b0, 32'h100, 3'd2, 0, ERR ? 32'h1 : 32'hCAFE_F00D);
        idle(1);

        // Two wait states
        tgt = 1'b1;
        xfer(2'd2, 1'b1, 32'h8, 3'd2, 32'hA5A5_A5A5, 0);
        chk("ws2_wr_stall", 32'(hready), 32'd0);
        idle(1);
        l0 = lowcnt;
        xfer(2'd2, 1'b0, 32'h8, 3'd2, 0, 32'hA5A5_A5A5);
        idle(1);
        chk("ws2_low_cycles", 32'(lowcnt - l0), 32'd2);
        xfer(2'd2, 1'b0, 32'h8, 3'd2, 0, 32'hA5A5_A5A5);
        c0 = cyc;
        xfer(2'd2, 1'b0, 32'hC, 3'd2, 0, 32'h0);
        chk("ws2_holdoff", 32'(cyc - c0), 32'd3);
        exp_q.delete(exp_q.size() - 1);
        rd_dp = 1'b0;
        idle(2);
        tgt = 1'b0;

        idle(2);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
